// File: rtl/south_bridge_ic.sv
// Peripheral-window decoder with NUM_DEV device slots plus a controller slot that
// holds a registered interrupt controller (mask, level/edge mode, W1C clear, miss counter).
module south_bridge_ic #(
  parameter int          NUM_DEV = 6,
  parameter int          SLOT_W  = 8,
  parameter logic [31:0] BASE    = 32'h0000_7F00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            Addr,
  input  logic [31:0]            WD,
  input  logic                   WE,
  output logic [31:0]            RD,
  output logic [NUM_DEV-1:0]     HWInt,
  output logic [SLOT_W-1:0]      DevAddr,
  output logic [31:0]            DevWD,
  output logic [NUM_DEV-1:0]     DevWE,
  input  logic [32*NUM_DEV-1:0]  DevRD,
  input  logic [NUM_DEV-1:0]     DevIRQ
);

  localparam int IDX_W = SLOT_W - 2;
  localparam logic [IDX_W-1:0] REG_STAT   = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0] REG_MASK   = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] REG_MODE   = IDX_W'(32'd2);
  localparam logic [IDX_W-1:0] REG_CLR    = IDX_W'(32'd3);
  localparam logic [IDX_W-1:0] REG_ERRCNT = IDX_W'(32'd4);

  logic [31:0]        off_s;
  logic [31:0]        slot_s;
  logic [IDX_W-1:0]   reg_idx_s;
  logic               hit_s;
  logic               ctrl_s;
  logic               miss_we_s;
  logic               wr_mask_s;
  logic               wr_mode_s;
  logic               wr_clr_s;
  logic               wr_err_s;
  logic [NUM_DEV-1:0] clr_s;
  logic [NUM_DEV-1:0] rise_s;
  logic [NUM_DEV-1:0] pending_s;
  logic [31:0]        ctrl_rd_s;

  logic [NUM_DEV-1:0] irq_q, irq_d;
  logic [NUM_DEV-1:0] irq_qq_q, irq_qq_d;
  logic               init_q, init_d;
  logic [NUM_DEV-1:0] pend_q, pend_d;
  logic [NUM_DEV-1:0] mask_q, mask_d;
  logic [NUM_DEV-1:0] mode_q, mode_d;
  logic [15:0]        errcnt_q, errcnt_d;
  logic [NUM_DEV-1:0] hwint_q, hwint_d;

  assign off_s     = Addr - BASE;
  assign slot_s    = off_s >> SLOT_W;
  assign reg_idx_s = off_s[SLOT_W-1:2];
  assign hit_s     = (Addr >= BASE) && (slot_s <= 32'(NUM_DEV));
  assign ctrl_s    = hit_s && (slot_s == 32'(NUM_DEV));
  assign miss_we_s = WE && !hit_s;
  assign wr_mask_s = WE && ctrl_s && (reg_idx_s == REG_MASK);
  assign wr_mode_s = WE && ctrl_s && (reg_idx_s == REG_MODE);
  assign wr_clr_s  = WE && ctrl_s && (reg_idx_s == REG_CLR);
  assign wr_err_s  = WE && ctrl_s && (reg_idx_s == REG_ERRCNT);

  assign DevAddr = off_s[SLOT_W-1:0];
  assign DevWD   = WD;
  assign HWInt   = hwint_q;

  // One-hot device write strobes
  always_comb begin
    DevWE = {NUM_DEV{1'b0}};
    for (int i = 0; i < NUM_DEV; i++) begin
      DevWE[i] = WE && hit_s && (slot_s == 32'(i));
    end
  end

  // Controller register read mux
  always_comb begin
    ctrl_rd_s = 32'h0000_0000;
    case (reg_idx_s)
      REG_STAT:   ctrl_rd_s = 32'(pending_s);
      REG_MASK:   ctrl_rd_s = 32'(mask_q);
      REG_MODE:   ctrl_rd_s = 32'(mode_q);
      REG_ERRCNT: ctrl_rd_s = {16'h0000, errcnt_q};
      default:    ctrl_rd_s = 32'h0000_0000;
    endcase
  end

  // Bus read data: device slot, controller slot or zero on a miss
  always_comb begin
    RD = 32'h0000_0000;
    if (ctrl_s) begin
      RD = ctrl_rd_s;
    end else if (hit_s) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if (slot_s == 32'(i)) begin
          RD = DevRD[32*i +: 32];
        end else begin
          RD = RD;
        end
      end
    end else begin
      RD = 32'h0000_0000;
    end
  end

  // Interrupt and register next-state logic
  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    errcnt_d = errcnt_q;
    clr_s    = {NUM_DEV{1'b0}};
    init_d   = 1'b0;
    irq_d    = DevIRQ;
    // Right after reset the second stage copies the input so a held line is not an edge.
    if (init_q) begin
      irq_qq_d = DevIRQ;
    end else begin
      irq_qq_d = irq_q;
    end
    if (wr_mask_s) begin
      mask_d = WD[NUM_DEV-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_mode_s) begin
      mode_d = WD[NUM_DEV-1:0];
    end else begin
      mode_d = mode_q;
    end
    if (wr_clr_s) begin
      clr_s = WD[NUM_DEV-1:0];
    end else begin
      clr_s = {NUM_DEV{1'b0}};
    end
    if (wr_err_s) begin
      errcnt_d = 16'h0000;
    end else if (miss_we_s && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
    rise_s    = irq_q & ~irq_qq_q;
    pend_d    = ((pend_q & ~clr_s) | rise_s) & mode_d;
    pending_s = (mode_q & pend_q) | (~mode_q & irq_q);
    hwint_d   = pending_s & mask_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q    <= {NUM_DEV{1'b0}};
      irq_qq_q <= {NUM_DEV{1'b0}};
      init_q   <= 1'b1;
      pend_q   <= {NUM_DEV{1'b0}};
      mask_q   <= {NUM_DEV{1'b1}};
      mode_q   <= {NUM_DEV{1'b0}};
      errcnt_q <= 16'h0000;
      hwint_q  <= {NUM_DEV{1'b0}};
    end else begin
      irq_q    <= irq_d;
      irq_qq_q <= irq_qq_d;
      init_q   <= init_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      errcnt_q <= errcnt_d;
      hwint_q  <= hwint_d;
    end
  end

endmodule
